bin_pool: RTL and testbench

Parametrised spatial binning stage for the 1-bit mask pipeline.
- Reduces a raster-order binary pixel stream to one result per 2^BIN_LOG2 × 2^BIN_LOG2 block.
- Each result carries the block's full ones count and a thresholded bit, with a run-time threshold.
- Tolerates idle cycles and ignores blanking.
- Sits between the per-pixel mask generator and the low-resolution consumers (centroid, frame buffer).

---
 rtl/bin_pool_if.sv | 32 +++
 rtl/bin_pool.sv | 94 +++++++++
 tb/tb_bin_pool.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bin_pool_if.sv
// Pixel-stream and binned-result bundle for bin_pool.
// The block side uses the slave modport; the pixel source/consumer uses master.
interface bin_pool_if #(
    parameter int BIN_LOG2 = 2,
    parameter int CNT_W    = 2 * BIN_LOG2 + 1
);
    logic                  pixel_valid_in;
    logic [10:0]           hcount_in;
    logic [9:0]            vcount_in;
    logic                  pixel_in;
    logic [CNT_W-1:0]      threshold_in;
    logic                  valid_out;
    logic [10-BIN_LOG2:0]  hcount_out;
    logic [9-BIN_LOG2:0]   vcount_out;
    logic [CNT_W-1:0]      count_out;
    logic                  binned_out;
    logic                  frame_done_out;

    modport master (
        output pixel_valid_in, hcount_in, vcount_in,
        output pixel_in, threshold_in,
        input  valid_out, hcount_out, vcount_out,
        input  count_out, binned_out, frame_done_out
    );

    modport slave (
        input  pixel_valid_in, hcount_in, vcount_in,
        input  pixel_in, threshold_in,
        output valid_out, hcount_out, vcount_out,
        output count_out, binned_out, frame_done_out
    );
endinterface

// File: rtl/bin_pool.sv
// Spatial binning of a raster 1-bit mask stream into per-block ones counts.
// Row partial sums live in a column buffer; a bin emits on its bottom-right pixel.
module bin_pool #(
    parameter int H_RES    = 1280,
    parameter int V_RES    = 720,
    parameter int BIN_LOG2 = 2,
    parameter int CNT_W    = 2 * BIN_LOG2 + 1
) (
    input logic         clk_in,
    input logic         rst_n_in,
    bin_pool_if.slave   bus
);
    localparam int NCOL  = H_RES >> BIN_LOG2;
    localparam int NROW  = V_RES >> BIN_LOG2;
    localparam int IDX_W = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int CW    = 11 - BIN_LOG2;
    localparam int RW    = 10 - BIN_LOG2;

    localparam logic [10:0]   H_LIM    = 11'(H_RES);
    localparam logic [9:0]    V_LIM    = 10'(V_RES);
    localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(NROW - 1);

    logic                accept;
    logic                group_end;
    logic [BIN_LOG2-1:0] sx;
    logic [BIN_LOG2-1:0] sy;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [IDX_W-1:0]    idx;
    logic [BIN_LOG2:0]   hacc;
    logic [BIN_LOG2:0]   g;
    logic [CNT_W-1:0]    acc_rd;
    logic [CNT_W-1:0]    total;
    logic                band_ok;

    logic [CNT_W-1:0]    col_buf [NCOL];

    assign accept = bus.pixel_valid_in
                 && (bus.hcount_in < H_LIM)
                 && (bus.vcount_in < V_LIM);

    assign sx  = bus.hcount_in[BIN_LOG2-1:0];
    assign sy  = bus.vcount_in[BIN_LOG2-1:0];
    assign col = bus.hcount_in[10:BIN_LOG2];
    assign row = bus.vcount_in[9:BIN_LOG2];
    assign idx = col[IDX_W-1:0];

    assign group_end = accept && (sx == '1);
    assign g         = hacc + {{BIN_LOG2{1'b0}}, bus.pixel_in};
    assign acc_rd    = col_buf[idx];
    assign total     = acc_rd + CNT_W'(g);

    // First band row overwrites, so the buffer never needs clearing.
    always_ff @(posedge clk_in) begin
        if (group_end && (sy != '1)) begin
            col_buf[idx] <= (sy == '0) ? CNT_W'(g) : total;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hacc               <= '0;
            band_ok            <= 1'b0;
            bus.valid_out      <= 1'b0;
            bus.hcount_out     <= '0;
            bus.vcount_out     <= '0;
            bus.count_out      <= '0;
            bus.binned_out     <= 1'b0;
            bus.frame_done_out <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            if (accept) begin
                if (sy == '0) begin
                    band_ok <= 1'b1;
                end
                unique case (1'b1)
                    (sx == '0): hacc <= {{BIN_LOG2{1'b0}}, bus.pixel_in};
                    (sx == '1): hacc <= '0;
                    default:    hacc <= g;
                endcase
            end
            // band_ok guards against stale sums left by a mid-band reset.
            if (group_end && (sy == '1) && band_ok) begin
                bus.valid_out      <= 1'b1;
                bus.count_out      <= total;
                bus.binned_out     <= (total >= bus.threshold_in);
                bus.hcount_out     <= col;
                bus.vcount_out     <= row;
                bus.frame_done_out <= (col == LAST_COL) && (row == LAST_ROW);
            end
        end
    end
endmodule

// File: tb/tb_bin_pool.sv
// Randomized bench for bin_pool: two configurations against a block-sum model.
// Expected bin results come from summing the stored frame over each block.
module tb_bin_pool;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bin_pool_if #(.BIN_LOG2(2)) ifa ();
    bin_pool_if #(.BIN_LOG2(3)) ifb ();

    bin_pool #(.H_RES(16), .V_RES(8), .BIN_LOG2(2)) dut_a (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (ifa)
    );

    bin_pool #(.H_RES(32), .V_RES(16), .BIN_LOG2(3)) dut_b (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (ifb)
    );

    int n_chk = 0;
    int n_err = 0;

    bit pix [32][16];
    bit pend = 1'b0;
    int p_col, p_row, p_cnt, p_bin, p_done;
    int cfg = 0;
    int thr = 0;
    bit quiet = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input int c, input string pfx);
        if (c == 0) begin
            chk({pfx, "_valid"}, int'(ifa.valid_out), 0);
            chk({pfx, "_count"}, int'(ifa.count_out), 0);
            chk({pfx, "_hcount"}, int'(ifa.hcount_out), 0);
            chk({pfx, "_vcount"}, int'(ifa.vcount_out), 0);
            chk({pfx, "_binned"}, int'(ifa.binned_out), 0);
            chk({pfx, "_done"}, int'(ifa.frame_done_out), 0);
        end else begin
            chk({pfx, "_valid"}, int'(ifb.valid_out), 0);
            chk({pfx, "_count"}, int'(ifb.count_out), 0);
            chk({pfx, "_hcount"}, int'(ifb.hcount_out), 0);
            chk({pfx, "_vcount"}, int'(ifb.vcount_out), 0);
            chk({pfx, "_binned"}, int'(ifb.binned_out), 0);
            chk({pfx, "_done"}, int'(ifb.frame_done_out), 0);
        end
    endtask

    task automatic sample();
        int vo, ho, vvo, co, bo, fo;
        if (cfg == 0) begin
            vo  = int'(ifa.valid_out);
            ho  = int'(ifa.hcount_out);
            vvo = int'(ifa.vcount_out);
            co  = int'(ifa.count_out);
            bo  = int'(ifa.binned_out);
            fo  = int'(ifa.frame_done_out);
        end else begin
            vo  = int'(ifb.valid_out);
            ho  = int'(ifb.hcount_out);
            vvo = int'(ifb.vcount_out);
            co  = int'(ifb.count_out);
            bo  = int'(ifb.binned_out);
            fo  = int'(ifb.frame_done_out);
        end
        chk("valid", vo, int'(pend));
        if (pend) begin
            chk("hcount", ho, p_col);
            chk("vcount", vvo, p_row);
            chk("count", co, p_cnt);
            chk("binned", bo, p_bin);
            chk("frame_done", fo, p_done);
        end
    endtask

    task automatic step(input bit v, input int h, input int vv, input bit p);
        int e, hr, vr;
        @(negedge clk);
        sample();
        ifa.pixel_valid_in = (cfg == 0) && v;
        ifa.hcount_in      = 11'(h);
        ifa.vcount_in      = 10'(vv);
        ifa.pixel_in       = p;
        ifa.threshold_in   = 5'(thr);
        ifb.pixel_valid_in = (cfg == 1) && v;
        ifb.hcount_in      = 11'(h);
        ifb.vcount_in      = 10'(vv);
        ifb.pixel_in       = p;
        ifb.threshold_in   = 7'(thr);
        e  = (cfg == 1) ? 8 : 4;
        hr = (cfg == 1) ? 32 : 16;
        vr = (cfg == 1) ? 16 : 8;
        pend = 1'b0;
        if (v && h < hr && vv < vr && !quiet
            && (h % e) == e - 1 && (vv % e) == e - 1) begin
            pend  = 1'b1;
            p_col = h / e;
            p_row = vv / e;
            p_cnt = 0;
            for (int x = p_col * e; x < p_col * e + e; x++)
                for (int y = p_row * e; y < p_row * e + e; y++)
                    p_cnt += int'(pix[x][y]);
            p_bin  = (p_cnt >= thr) ? 1 : 0;
            p_done = (p_col == hr / e - 1 && p_row == vr / e - 1) ? 1 : 0;
        end
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1 chk_zero(cfg, "midrst");
        #1 rst_n = 1'b1;
        pend  = 1'b0;
        quiet = 1'b1;
    endtask

    task automatic run_frame(input int c, input int pat, input int idle,
                             input bit blank, input int rh, input int rv,
                             input int t);
        int hr, vr, hx, vx;
        cfg   = c;
        thr   = t;
        quiet = 1'b0;
        hr = (c == 1) ? 32 : 16;
        vr = (c == 1) ? 16 : 8;
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 16; y++)
                case (pat)
                    0: pix[x][y] = 1'b1;
                    1: pix[x][y] = ((x + y) % 2) == 0;
                    2: pix[x][y] = (x == 5 && y == 6);
                    default: pix[x][y] = 1'($urandom_range(1, 0));
                endcase
        hx = hr + (blank ? 4 : 0);
        vx = vr + (blank ? 2 : 0);
        for (int vv = 0; vv < vx; vv++) begin
            for (int h = 0; h < hx; h++) begin
                if (h == rh && vv == rv) pulse_reset();
                while ($urandom_range(99, 0) < idle) step(1'b0, h, vv, 1'b1);
                step(1'b1, h, vv, (h < hr && vv < vr) ? pix[h][vv] : 1'b1);
            end
        end
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        ifa.pixel_valid_in = 1'b0;
        ifa.hcount_in = '0;
        ifa.vcount_in = '0;
        ifa.pixel_in = 1'b0;
        ifa.threshold_in = '0;
        ifb.pixel_valid_in = 1'b0;
        ifb.hcount_in = '0;
        ifb.vcount_in = '0;
        ifb.pixel_in = 1'b0;
        ifb.threshold_in = '0;
        #2;
        chk_zero(0, "reset_a");
        chk_zero(1, "reset_b");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_frame(0, 0, 0, 1'b0, -1, -1, 8);
        run_frame(0, 1, 0, 1'b0, -1, -1, 8);
        run_frame(0, 1, 0, 1'b0, -1, -1, 9);
        run_frame(0, 2, 0, 1'b0, -1, -1, 1);
        run_frame(0, 2, 0, 1'b0, -1, -1, 0);
        run_frame(0, 0, 50, 1'b1, -1, -1, 8);
        run_frame(0, 0, 0, 1'b0, 3, 5, 8);
        run_frame(0, 0, 0, 1'b0, -1, -1, 8);
        run_frame(0, 0, 0, 1'b0, -1, -1, 17);
        run_frame(0, 3, 30, 1'b1, -1, -1, int'($urandom_range(17, 0)));
        run_frame(0, 3, 0, 1'b0, -1, -1, int'($urandom_range(17, 0)));
        run_frame(1, 0, 0, 1'b0, -1, -1, 64);
        run_frame(1, 3, 20, 1'b1, -1, -1, int'($urandom_range(65, 0)));
        run_frame(1, 3, 0, 1'b0, -1, -1, int'($urandom_range(65, 0)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
